// File: rtl/hex_scan_ctrl.sv
// Multiplexed 4-digit common-anode 7-seg scanner with blanking gaps and frame-synchronous value updates.
// Optional build macro HEX_SCAN_LZB_EN enables leading-zero blanking of digits 3..1.
module hex_scan_ctrl #(
  parameter int REFRESH_EXP  = 16,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  output logic        load_ack_o,
  output logic [3:0]  an_o,
  output logic [7:0]  seg_o,
  output logic [1:0]  digit_o,
  output logic        frame_o
);

  localparam int BLANK_EFF = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
  localparam int BLANK_W   = $clog2(BLANK_EFF + 1);
  localparam int CW        = (REFRESH_EXP > BLANK_W) ? REFRESH_EXP : BLANK_W;
  localparam logic [CW-1:0] DRIVE_LAST = CW'((64'd1 << REFRESH_EXP) - 64'd1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_EFF - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    digit, digit_n;
  logic [15:0]   shadow_val, shadow_val_n, pend_val, pend_val_n;
  logic [3:0]    shadow_dp, shadow_dp_n, pend_dp, pend_dp_n;
  logic          pend_flag, pend_flag_n;
  logic          ack_n, frame_n;
  logic [3:0]    an_n;
  logic [7:0]    seg_n;
  logic          shown;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 8'hC0;
      4'h1: hex_to_seg = 8'hF9;
      4'h2: hex_to_seg = 8'hA4;
      4'h3: hex_to_seg = 8'hB0;
      4'h4: hex_to_seg = 8'h99;
      4'h5: hex_to_seg = 8'h92;
      4'h6: hex_to_seg = 8'h82;
      4'h7: hex_to_seg = 8'hF8;
      4'h8: hex_to_seg = 8'h80;
      4'h9: hex_to_seg = 8'h90;
      4'hA: hex_to_seg = 8'h88;
      4'hB: hex_to_seg = 8'h83;
      4'hC: hex_to_seg = 8'hC6;
      4'hD: hex_to_seg = 8'hA1;
      4'hE: hex_to_seg = 8'h86;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  // Next-state view of the scanner; outputs are registered from these values so they line up with state.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    digit_n      = digit;
    shadow_val_n = shadow_val;
    shadow_dp_n  = shadow_dp;
    pend_val_n   = pend_val;
    pend_dp_n    = pend_dp;
    pend_flag_n  = pend_flag;
    ack_n        = 1'b0;
    frame_n      = 1'b0;

    if (!enable_i) begin
      // Dark display: nothing to tear, so loads bypass the pending stage.
      state_n = ST_BLANK;
      cnt_n   = '0;
      digit_n = 2'd0;
      if (load_i) begin
        shadow_val_n = value_i;
        shadow_dp_n  = dp_i;
        pend_flag_n  = 1'b0;
        ack_n        = 1'b1;
      end
    end else begin
      if (state == ST_BLANK) begin
        if (cnt == BLANK_LAST) begin
          state_n = ST_DRIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end else begin
        if (cnt == DRIVE_LAST) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          digit_n = digit + 2'd1;
          frame_n = (digit == 2'd3);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      if (frame_n) begin
        if (load_i) begin
          shadow_val_n = value_i;
          shadow_dp_n  = dp_i;
          pend_flag_n  = 1'b0;
          ack_n        = 1'b1;
        end else if (pend_flag) begin
          shadow_val_n = pend_val;
          shadow_dp_n  = pend_dp;
          pend_flag_n  = 1'b0;
          ack_n        = 1'b1;
        end
      end else if (load_i) begin
        pend_val_n  = value_i;
        pend_dp_n   = dp_i;
        pend_flag_n = 1'b1;
      end
    end
  end

  always_comb begin
    shown = (state_n == ST_DRIVE);
`ifdef HEX_SCAN_LZB_EN
    if ((digit_n != 2'd0) && ((shadow_val_n >> {digit_n, 2'b00}) == 16'h0000))
      shown = 1'b0;
`endif
    an_n  = 4'hF;
    seg_n = 8'hFF;
    if (shown) begin
      an_n  = ~(4'b0001 << digit_n);
      seg_n = hex_to_seg(shadow_val_n[{digit_n, 2'b00} +: 4]) & {~shadow_dp_n[digit_n], 7'h7F};
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      digit      <= 2'd0;
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      pend_val   <= 16'h0000;
      pend_dp    <= 4'h0;
      pend_flag  <= 1'b0;
      load_ack_o <= 1'b0;
      frame_o    <= 1'b0;
      an_o       <= 4'hF;
      seg_o      <= 8'hFF;
      digit_o    <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit      <= digit_n;
      shadow_val <= shadow_val_n;
      shadow_dp  <= shadow_dp_n;
      pend_val   <= pend_val_n;
      pend_dp    <= pend_dp_n;
      pend_flag  <= pend_flag_n;
      load_ack_o <= ack_n;
      frame_o    <= frame_n;
      an_o       <= an_n;
      seg_o      <= seg_n;
      digit_o    <= digit_n;
    end
  end

endmodule
